// File: rtl/wb_arbiter.sv
// Two-master round-robin Wishbone arbiter with outstanding-request count and ack watchdog.
// Latency: one cycle to grant from idle; all forwarding is combinational while granted.
// Backpressure: ungranted master sees stall; granted master stalls on slave stall or a full counter.
module wb_arbiter #(
    parameter int unsigned TIMEOUT = 255,
    parameter int unsigned OUT_W   = 4
) (
    input  logic        i_core_clk,
    input  logic        i_rst,
    input  logic        i_m0_cyc,
    input  logic        i_m0_stb,
    input  logic        i_m0_we,
    input  logic [15:0] i_m0_adr,
    input  logic [15:0] i_m0_dat,
    output logic        o_m0_ack,
    output logic        o_m0_stall,
    output logic [15:0] o_m0_dat,
    input  logic        i_m1_cyc,
    input  logic        i_m1_stb,
    input  logic        i_m1_we,
    input  logic [15:0] i_m1_adr,
    input  logic [15:0] i_m1_dat,
    output logic        o_m1_ack,
    output logic        o_m1_stall,
    output logic [15:0] o_m1_dat,
    output logic        o_s_cyc,
    output logic        o_s_stb,
    output logic        o_s_we,
    output logic [15:0] o_s_adr,
    output logic [15:0] o_s_dat,
    input  logic        i_s_ack,
    input  logic        i_s_stall,
    input  logic [15:0] i_s_dat,
    output logic        o_timeout,
    output logic [1:0]  o_owner
);

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        GNT0  = 2'b01,
        GNT1  = 2'b10,
        ABORT = 2'b11
    } state_t;

    state_t           r_state;
    logic             r_rr;
    logic [OUT_W-1:0] r_cnt;
    logic [15:0]      r_wd;
    logic             r_timeout;
    logic [1:0]       r_owner;

    logic        w_gnt0;
    logic        w_gnt1;
    logic        w_gnt;
    logic        w_cyc;
    logic        w_stb;
    logic        w_we;
    logic [15:0] w_adr;
    logic [15:0] w_dat;
    logic        w_other_cyc;
    logic        w_full;
    logic        w_live;
    logic        w_stall;
    logic        w_acc;
    logic        w_ack;
    logic [16:0] w_wd_inc;
    logic        w_wd_fire;

    assign w_gnt0      = (r_state == GNT0);
    assign w_gnt1      = (r_state == GNT1);
    assign w_gnt       = w_gnt0 | w_gnt1;
    assign w_cyc       = w_gnt1 ? i_m1_cyc : i_m0_cyc;
    assign w_stb       = w_gnt1 ? i_m1_stb : i_m0_stb;
    assign w_we        = w_gnt1 ? i_m1_we  : i_m0_we;
    assign w_adr       = w_gnt1 ? i_m1_adr : i_m0_adr;
    assign w_dat       = w_gnt1 ? i_m1_dat : i_m0_dat;
    assign w_other_cyc = w_gnt1 ? i_m0_cyc : i_m1_cyc;

    assign w_full  = &r_cnt;
    assign w_live  = |r_cnt;
    assign w_stall = i_s_stall | w_full;
    assign w_acc   = o_s_stb & ~i_s_stall;
    // Acks with nothing in flight are spurious and never reach a master.
    assign w_ack   = w_gnt & w_live & i_s_ack;

    assign w_wd_inc  = {1'b0, r_wd} + 17'd1;
    assign w_wd_fire = w_live & ~i_s_ack & (w_wd_inc == 17'(TIMEOUT));

    assign o_s_cyc = w_gnt & w_cyc;
    assign o_s_stb = w_gnt & w_stb & ~w_full;
    assign o_s_we  = w_we;
    assign o_s_adr = w_adr;
    assign o_s_dat = w_dat;

    assign o_m0_ack   = w_gnt0 & w_ack;
    assign o_m0_stall = ~w_gnt0 | w_stall;
    assign o_m0_dat   = w_gnt0 ? i_s_dat : 16'h0000;
    assign o_m1_ack   = w_gnt1 & w_ack;
    assign o_m1_stall = ~w_gnt1 | w_stall;
    assign o_m1_dat   = w_gnt1 ? i_s_dat : 16'h0000;

    assign o_timeout = r_timeout;
    assign o_owner   = r_owner;

    // r_rr names the master served last; a tie in IDLE goes to the other one.
    always_ff @(posedge i_core_clk) begin
        if (i_rst) begin
            r_state   <= IDLE;
            r_rr      <= 1'b1;
            r_cnt     <= '0;
            r_wd      <= '0;
            r_timeout <= 1'b0;
            r_owner   <= 2'b00;
        end else begin
            r_timeout <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (i_m0_cyc && (!i_m1_cyc || r_rr)) begin
                        r_state <= GNT0;
                        r_owner <= 2'b01;
                    end else if (i_m1_cyc) begin
                        r_state <= GNT1;
                        r_owner <= 2'b10;
                    end
                end
                GNT0, GNT1: begin
                    if (!w_cyc) begin
                        r_cnt <= '0;
                        r_wd  <= '0;
                        r_rr  <= w_gnt1;
                        if (w_other_cyc) begin
                            r_state <= w_gnt1 ? GNT0 : GNT1;
                            r_owner <= w_gnt1 ? 2'b01 : 2'b10;
                        end else begin
                            r_state <= IDLE;
                            r_owner <= 2'b00;
                        end
                    end else if (w_wd_fire) begin
                        r_state   <= ABORT;
                        r_owner   <= 2'b00;
                        r_timeout <= 1'b1;
                        r_cnt     <= '0;
                        r_wd      <= '0;
                        r_rr      <= w_gnt1;
                    end else begin
                        case ({w_acc, w_ack})
                            2'b10:   r_cnt <= r_cnt + OUT_W'(1);
                            2'b01:   r_cnt <= r_cnt - OUT_W'(1);
                            default: r_cnt <= r_cnt;
                        endcase
                        r_wd <= (w_live && !i_s_ack) ? w_wd_inc[15:0] : 16'h0000;
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_owner <= 2'b00;
                end
            endcase
        end
    end

endmodule
